// File: rtl/irst_fetch_ctrl.sv
// Fetch PC controller with an in-field RAM self-test sweep.
// Functional mode advances/branches the PC; test mode alternates READ/WRITE sweeps over [irst_lo, irst_hi].
module irst_fetch_ctrl #(
    parameter int PC_WIDTH  = 8,
    parameter int OFF_WIDTH = 6,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 branch_taken,
    input  logic [OFF_WIDTH-1:0] branch_offset,
    input  logic                 irst_start,
    input  logic [PC_WIDTH-2:0]  irst_lo,
    input  logic [PC_WIDTH-2:0]  irst_hi,
    input  logic [CNT_WIDTH-1:0] irst_passes,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 write_en,
    output logic                 irst_busy,
    output logic                 irst_done,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [1:0]           state_dbg
);

    localparam int AW = PC_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_FUNC  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_reg_q, pc_reg_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;

    logic [PC_WIDTH-1:0]  offset_ext;
    logic                 sweep_end;

    assign offset_ext = PC_WIDTH'($signed(branch_offset));
    // An inverted range (lo > hi) lands on lo with addr >= hi, so every advance ends the sweep.
    assign sweep_end  = (addr_q >= irst_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FUNC;
            pc_reg_q   <= '0;
            addr_q     <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_reg_q   <= pc_reg_d;
            addr_q     <= addr_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_reg_d   = pc_reg_q;
        addr_d     = addr_q;
        pass_cnt_d = pass_cnt_q;
        case (state_q)
            ST_FUNC: begin
                if (irst_start) begin
                    state_d    = ST_READ;
                    addr_d     = irst_lo;
                    pass_cnt_d = '0;
                end else if (fetch_en) begin
                    if (branch_taken) pc_reg_d = pc_reg_q + offset_ext;
                    else              pc_reg_d = pc_reg_q + PC_WIDTH'(1);
                end
            end
            ST_READ, ST_WRITE: begin
                // Abort wins over any end-of-sweep decision in the same cycle.
                if (!irst_start) begin
                    state_d  = ST_FUNC;
                    pc_reg_d = '0;
                end else if (fetch_en) begin
                    if (!sweep_end) begin
                        addr_d = addr_q + AW'(1);
                    end else begin
                        addr_d = irst_lo;
                        if (state_q == ST_WRITE) begin
                            state_d = ST_READ;
                        end else if (pass_cnt_q < irst_passes) begin
                            state_d    = ST_WRITE;
                            pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!irst_start) begin
                    state_d  = ST_FUNC;
                    pc_reg_d = '0;
                end
            end
            default: state_d = ST_FUNC;
        endcase
    end

    always_comb begin
        pc        = pc_reg_q;
        write_en  = 1'b0;
        irst_busy = 1'b0;
        irst_done = 1'b0;
        case (state_q)
            ST_READ: begin
                pc        = {1'b0, addr_q};
                irst_busy = 1'b1;
            end
            ST_WRITE: begin
                pc        = {1'b1, addr_q};
                write_en  = 1'b1;
                irst_busy = 1'b1;
            end
            ST_DONE: begin
                pc        = {1'b0, addr_q};
                irst_done = 1'b1;
            end
            default: pc = pc_reg_q;
        endcase
    end

    assign pass_cnt  = pass_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_irst_fetch_ctrl.sv
// Directed bench for irst_fetch_ctrl: functional PC stepping, test sweeps, abort, stall, reset.
module tb_irst_fetch_ctrl;

    localparam logic [1:0] S_FUNC  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_en;
    logic       branch_taken;
    logic [5:0] branch_offset;
    logic       irst_start;
    logic [6:0] irst_lo;
    logic [6:0] irst_hi;
    logic [5:0] irst_passes;
    logic [7:0] pc;
    logic       write_en;
    logic       irst_busy;
    logic       irst_done;
    logic [5:0] pass_cnt;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    irst_fetch_ctrl #(.PC_WIDTH(8), .OFF_WIDTH(6), .CNT_WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .irst_start    (irst_start),
        .irst_lo       (irst_lo),
        .irst_hi       (irst_hi),
        .irst_passes   (irst_passes),
        .pc            (pc),
        .write_en      (write_en),
        .irst_busy     (irst_busy),
        .irst_done     (irst_done),
        .pass_cnt      (pass_cnt),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; branch_taken = 1'b0; branch_offset = '0;
        irst_start = 1'b0; irst_lo = '0; irst_hi = '0; irst_passes = '0;
        step(2);
        rst = 1'b0; fetch_en = 1'b0;
        checks++;
        if (pc !== 8'd0 || write_en !== 1'b0 || irst_busy !== 1'b0 || irst_done !== 1'b0 ||
            pass_cnt !== 6'd0 || state_dbg !== S_FUNC) begin
            errors++;
            $display("FAIL reset: pc=%0d we=%b busy=%b done=%b pass=%0d st=%0d, want 0 0 0 0 0 0",
                     pc, write_en, irst_busy, irst_done, pass_cnt, state_dbg);
        end
    endtask

    task automatic test_functional();
        logic [7:0] exp_pc [8];
        logic       br     [8];
        logic [5:0] off    [8];
        logic       fe     [8];
        exp_pc = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd255, 8'd0, 8'd31, 8'd31};
        br     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1'b0, 1'b1,  1'b1};
        off    = '{6'h00, 6'h00, 6'h00, 6'h3E, 6'h3E, 6'h00, 6'h1F, 6'h1F};
        fe     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1,  1'b0};
        for (int i = 0; i < 8; i++) begin
            fetch_en = fe[i]; branch_taken = br[i]; branch_offset = off[i];
            step();
            checks++;
            if (pc !== exp_pc[i] || state_dbg !== S_FUNC || write_en !== 1'b0) begin
                errors++;
                $display("FAIL functional[%0d]: pc=%0d st=%0d we=%b, want pc=%0d st=0 we=0",
                         i, pc, state_dbg, write_en, exp_pc[i]);
            end
        end
        fetch_en = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_pc [9];
        logic       exp_we [9];
        logic [5:0] exp_pc_cnt [9];
        exp_pc     = '{8'd2, 8'd3, 8'd4, 8'd130, 8'd131, 8'd132, 8'd2, 8'd3, 8'd4};
        exp_we     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_pc_cnt = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
        irst_lo = 7'd2; irst_hi = 7'd4; irst_passes = 6'd1;
        irst_start = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (pc !== exp_pc[i] || write_en !== exp_we[i] || irst_busy !== 1'b1 ||
                irst_done !== 1'b0 || pass_cnt !== exp_pc_cnt[i]) begin
                errors++;
                $display("FAIL sweep[%0d]: pc=%0d we=%b busy=%b done=%b pass=%0d, want pc=%0d we=%b busy=1 done=0 pass=%0d",
                         i, pc, write_en, irst_busy, irst_done, pass_cnt, exp_pc[i], exp_we[i], exp_pc_cnt[i]);
            end
        end
        step();
        checks++;
        if (irst_done !== 1'b1 || irst_busy !== 1'b0 || pass_cnt !== 6'd1 ||
            write_en !== 1'b0 || pc !== 8'd2 || state_dbg !== S_DONE) begin
            errors++;
            $display("FAIL sweep_done: done=%b busy=%b pass=%0d we=%b pc=%0d st=%0d, want 1 0 1 0 2 3",
                     irst_done, irst_busy, pass_cnt, write_en, pc, state_dbg);
        end
        irst_start = 1'b0;
        step();
        checks++;
        if (pc !== 8'd0 || irst_done !== 1'b0 || state_dbg !== S_FUNC || pass_cnt !== 6'd1) begin
            errors++;
            $display("FAIL sweep_release: pc=%0d done=%b st=%0d pass=%0d, want 0 0 0 1",
                     pc, irst_done, state_dbg, pass_cnt);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_zero_passes();
        irst_lo = 7'd5; irst_hi = 7'd5; irst_passes = 6'd0;
        irst_start = 1'b1; fetch_en = 1'b1;
        step();
        checks++;
        if (pc !== 8'd5 || write_en !== 1'b0 || irst_busy !== 1'b1 || state_dbg !== S_READ) begin
            errors++;
            $display("FAIL zero_read: pc=%0d we=%b busy=%b st=%0d, want 5 0 1 1", pc, write_en, irst_busy, state_dbg);
        end
        step();
        checks++;
        if (irst_done !== 1'b1 || write_en !== 1'b0 || pass_cnt !== 6'd0 || pc !== 8'd5) begin
            errors++;
            $display("FAIL zero_done: done=%b we=%b pass=%0d pc=%0d, want 1 0 0 5", irst_done, write_en, pass_cnt, pc);
        end
        step(2);
        checks++;
        if (irst_done !== 1'b1 || state_dbg !== S_DONE || pc !== 8'd5) begin
            errors++;
            $display("FAIL zero_hold: done=%b st=%0d pc=%0d, want 1 3 5", irst_done, state_dbg, pc);
        end
        irst_start = 1'b0;
        step();
        checks++;
        if (pc !== 8'd0 || state_dbg !== S_FUNC || irst_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_release: pc=%0d st=%0d done=%b, want 0 0 0", pc, state_dbg, irst_done);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_abort();
        irst_lo = 7'd0; irst_hi = 7'd7; irst_passes = 6'd2;
        irst_start = 1'b1; fetch_en = 1'b1;
        step(12);
        checks++;
        if (pc !== 8'd131 || write_en !== 1'b1 || pass_cnt !== 6'd1) begin
            errors++;
            $display("FAIL abort_pre: pc=%0d we=%b pass=%0d, want 131 1 1", pc, write_en, pass_cnt);
        end
        irst_start = 1'b0;
        step();
        checks++;
        if (pc !== 8'd0 || write_en !== 1'b0 || irst_busy !== 1'b0 || state_dbg !== S_FUNC || pass_cnt !== 6'd1) begin
            errors++;
            $display("FAIL abort: pc=%0d we=%b busy=%b st=%0d pass=%0d, want 0 0 0 0 1",
                     pc, write_en, irst_busy, state_dbg, pass_cnt);
        end
        step();
        checks++;
        if (pc !== 8'd1) begin
            errors++;
            $display("FAIL abort_resume: pc=%0d, want 1", pc);
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_stall();
        irst_lo = 7'd0; irst_hi = 7'd7; irst_passes = 6'd1;
        irst_start = 1'b1; fetch_en = 1'b1;
        step(4);
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 8'd3 || state_dbg !== S_READ || write_en !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%0d st=%0d we=%b, want 3 1 0", i, pc, state_dbg, write_en);
            end
        end
        fetch_en = 1'b1;
        step();
        checks++;
        if (pc !== 8'd4 || state_dbg !== S_READ) begin
            errors++;
            $display("FAIL stall_resume: pc=%0d st=%0d, want 4 1", pc, state_dbg);
        end
        irst_start = 1'b0;
        step();
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] exp_pc [5];
        logic       exp_we [5];
        exp_pc = '{8'd6, 8'd134, 8'd6, 8'd134, 8'd6};
        exp_we = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        irst_lo = 7'd0; irst_hi = 7'd7; irst_passes = 6'd2;
        irst_start = 1'b1; fetch_en = 1'b1;
        step(11);
        checks++;
        if (pc !== 8'd130 || write_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: pc=%0d we=%b, want 130 1", pc, write_en);
        end
        rst = 1'b1;
        step();
        checks++;
        if (pc !== 8'd0 || write_en !== 1'b0 || irst_busy !== 1'b0 || irst_done !== 1'b0 ||
            pass_cnt !== 6'd0 || state_dbg !== S_FUNC) begin
            errors++;
            $display("FAIL rst_mid: pc=%0d we=%b busy=%b done=%b pass=%0d st=%0d, want all 0",
                     pc, write_en, irst_busy, irst_done, pass_cnt, state_dbg);
        end
        rst = 1'b0; irst_lo = 7'd6; irst_hi = 7'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pc !== exp_pc[i] || write_en !== exp_we[i] || irst_busy !== 1'b1) begin
                errors++;
                $display("FAIL inverted[%0d]: pc=%0d we=%b busy=%b, want pc=%0d we=%b busy=1",
                         i, pc, write_en, irst_busy, exp_pc[i], exp_we[i]);
            end
        end
        step();
        checks++;
        if (irst_done !== 1'b1 || pass_cnt !== 6'd2 || pc !== 8'd6) begin
            errors++;
            $display("FAIL inverted_done: done=%b pass=%0d pc=%0d, want 1 2 6", irst_done, pass_cnt, pc);
        end
        irst_start = 1'b0; fetch_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_functional();
        test_sweep();
        test_zero_passes();
        test_abort();
        test_stall();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
